// File: rtl/pc_fetch_if.sv
// Fetch-side bundle of the PC fetch unit: redirect inputs, the instruction
// memory handshake, and the PC/counter observation outputs.
interface pc_fetch_if;
  logic        Branch;
  logic [31:0] BranchOffset32;
  logic        Jump;
  logic [25:0] JumpTarget26;
  logic        Stall;
  logic        IAck;
  logic        IReq;
  logic [31:0] IAddr;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic [15:0] FetchCnt;

  modport master (
    input  Branch, BranchOffset32, Jump, JumpTarget26, Stall, IAck,
    output IReq, IAddr, PC, PCPlus4, FetchCnt
  );

  modport slave (
    output Branch, BranchOffset32, Jump, JumpTarget26, Stall, IAck,
    input  IReq, IAddr, PC, PCPlus4, FetchCnt
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch request generator with branch/jump
// redirect, single-entry pending redirect latch and accepted-fetch counter.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic         Clk,
  input logic         Rst_n,
  pc_fetch_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic        pend_valid_reg, pend_valid_next;
  logic [31:0] pend_target_reg, pend_target_next;
  logic [15:0] fetch_cnt_reg, fetch_cnt_next;

  logic        accept;
  logic [31:0] pc_plus4;
  logic [31:0] jump_target;
  logic [31:0] branch_sum;
  logic [31:0] branch_target;
  logic [31:0] redirect_target;

  assign pc_plus4      = pc_reg + 32'd4;
  assign jump_target   = {pc_plus4[31:28], bus.JumpTarget26, 2'b00};
  assign branch_sum    = pc_plus4 + bus.BranchOffset32;
  assign branch_target = {branch_sum[31:2], 2'b00};
  // Jump outranks Branch for both the live selection and the pending latch.
  assign redirect_target = bus.Jump ? jump_target : branch_target;

  assign accept = (state_reg == REQ) && bus.IAck && !bus.Stall;

  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    pend_valid_next  = pend_valid_reg;
    pend_target_next = pend_target_reg;
    fetch_cnt_next   = fetch_cnt_reg;

    case (state_reg)
      IDLE:    state_next = bus.Stall ? HOLD : REQ;
      REQ:     state_next = bus.Stall ? HOLD : REQ;
      HOLD:    state_next = bus.Stall ? HOLD : REQ;
      default: state_next = IDLE;
    endcase

    if (accept) begin
      fetch_cnt_next  = fetch_cnt_reg + 16'd1;
      pend_valid_next = 1'b0;
      if (bus.Jump || bus.Branch)
        pc_next = redirect_target;
      else if (pend_valid_reg)
        pc_next = pend_target_reg;
      else
        pc_next = pc_plus4;
    end else if (bus.Jump || bus.Branch) begin
      // Redirect seen while the fetch is not taken: remember the newest one.
      pend_valid_next  = 1'b1;
      pend_target_next = redirect_target;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_reg       <= IDLE;
      pc_reg          <= RESET_PC;
      pend_valid_reg  <= 1'b0;
      pend_target_reg <= 32'h0000_0000;
      fetch_cnt_reg   <= 16'h0000;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      pend_valid_reg  <= pend_valid_next;
      pend_target_reg <= pend_target_next;
      fetch_cnt_reg   <= fetch_cnt_next;
    end
  end

  // IReq decodes the state register directly so reset drops it at once.
  assign bus.IReq     = (state_reg == REQ);
  assign bus.IAddr    = pc_reg;
  assign bus.PC       = pc_reg;
  assign bus.PCPlus4  = pc_plus4;
  assign bus.FetchCnt = fetch_cnt_reg;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a reference model pushes the expected
// post-edge PC/count to a scoreboard queue, popped after every clock edge.
module tb_pc_fetch_unit;

  logic Clk;
  logic Rst_n;

  pc_fetch_if bus ();

  pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] pc;
    logic [15:0] cnt;
    logic        ireq;
  } exp_t;

  exp_t sb_q[$];

  int tests_run = 0;
  int tests_failed = 0;

  // reference model state: 0 = IDLE, 1 = REQ, 2 = HOLD
  int          m_state;
  logic [31:0] m_pc;
  logic [15:0] m_cnt;
  logic        m_pv;
  logic [31:0] m_pt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_pc    = 32'h0;
    m_cnt   = 16'h0;
    m_pv    = 1'b0;
    m_pt    = 32'h0;
  endtask

  // One clock cycle with inputs already driven: check current outputs,
  // predict the next state, clock, then pop and compare.
  task automatic tick(input string tag);
    logic [31:0] p4, jt, bs, bt, rt;
    logic        acc;
    exp_t        e, got;
    chk({tag, ".ireq"},  {31'd0, bus.IReq}, {31'd0, m_state == 1});
    chk({tag, ".iaddr"}, bus.IAddr, m_pc);
    p4  = m_pc + 32'd4;
    jt  = {p4[31:28], bus.JumpTarget26, 2'b00};
    bs  = p4 + bus.BranchOffset32;
    bt  = bs & 32'hFFFF_FFFC;
    rt  = bus.Jump ? jt : bt;
    acc = (m_state == 1) && bus.IAck && !bus.Stall;
    if (acc) begin
      m_pc  = (bus.Jump || bus.Branch) ? rt : (m_pv ? m_pt : p4);
      m_cnt = m_cnt + 16'd1;
      m_pv  = 1'b0;
    end else if (bus.Jump || bus.Branch) begin
      m_pv = 1'b1;
      m_pt = rt;
    end
    m_state = bus.Stall ? 2 : 1;
    e.pc = m_pc; e.cnt = m_cnt; e.ireq = (m_state == 1);
    sb_q.push_back(e);
    @(posedge Clk);
    #1;
    got = sb_q.pop_front();
    chk({tag, ".pc"},  bus.PC, got.pc);
    chk({tag, ".cnt"}, {16'd0, bus.FetchCnt}, {16'd0, got.cnt});
    chk({tag, ".ireq_next"}, {31'd0, bus.IReq}, {31'd0, got.ireq});
  endtask

  task automatic set_in(input logic b, input logic [31:0] off, input logic j,
                        input logic [25:0] jt, input logic st, input logic ack);
    bus.Branch = b; bus.BranchOffset32 = off; bus.Jump = j;
    bus.JumpTarget26 = jt; bus.Stall = st; bus.IAck = ack;
  endtask

  initial begin
    Rst_n = 1'b0;
    set_in(0, 32'h0, 0, 26'h0, 0, 0);
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    chk("reset.pc",   bus.PC, 32'h0);
    chk("reset.ireq", {31'd0, bus.IReq}, 32'd0);
    chk("reset.cnt",  {16'd0, bus.FetchCnt}, 32'd0);
    Rst_n = 1'b1;
    #1;
    chk("release.pc_held", bus.PC, 32'h0);

    // Sequential fetch: IDLE cycle, then 0, 4, 8 accepted.
    set_in(0, 32'h0, 0, 26'h0, 0, 1);
    tick("idle");
    tick("seq0");
    tick("seq1");
    tick("seq2");
    chk("seq.addr12", bus.IAddr, 32'd12);
    chk("seq.cnt3",   {16'd0, bus.FetchCnt}, 32'd3);

    // Jump into 0x100, then branch +0x20 -> 0x124.
    set_in(0, 32'h0, 1, 26'h40, 0, 1);
    tick("jump100");
    chk("jump.pc", bus.PC, 32'h0000_0100);
    set_in(1, 32'h20, 0, 26'h0, 0, 1);
    tick("branch");
    chk("branch.pc", bus.PC, 32'h0000_0124);

    // Move to 0x1000_0000, then a jump while IAck=0 must be held pending.
    set_in(1, 32'h0FFF_FED8, 0, 26'h0, 0, 1);
    tick("to1000");
    set_in(0, 32'h0, 1, 26'h40, 0, 0);
    tick("pend_jump");
    chk("pend.pc_stable", bus.PC, 32'h1000_0000);
    set_in(0, 32'h0, 0, 26'h0, 0, 1);
    tick("pend_apply");
    chk("pend.pc", bus.PC, 32'h1000_0100);
    chk("pend.valid_clear", {31'd0, dut.pend_valid_reg}, 32'd0);

    // Jump beats branch in the same cycle.
    set_in(1, 32'h40, 1, 26'h80, 0, 1);
    tick("prio");
    chk("prio.pc", bus.PC, 32'h1000_0200);

    // Two pending redirects: only the newer jump lands.
    set_in(1, 32'h13, 0, 26'h0, 0, 0);
    tick("ovw_branch");
    set_in(0, 32'h0, 1, 26'h10, 0, 0);
    tick("ovw_jump");
    set_in(0, 32'h0, 0, 26'h0, 0, 1);
    tick("ovw_apply");
    chk("ovw.pc", bus.PC, 32'h1000_0040);

    // Branch with unaligned sum lands on 0xFFFF_FFFC, then PC+4 wraps to 0.
    set_in(1, 32'hEFFF_FFBB, 0, 26'h0, 0, 1);
    tick("toFFFC");
    chk("wrap.pc",      bus.PC, 32'hFFFF_FFFC);
    chk("wrap.pcplus4", bus.PCPlus4, 32'h0000_0000);
    set_in(0, 32'h0, 0, 26'h0, 0, 1);
    tick("wrap");
    chk("wrap.pc0", bus.PC, 32'h0);

    // Stall for 3 cycles with IAck high: nothing moves, IAck ignored in HOLD.
    set_in(0, 32'h0, 0, 26'h0, 1, 1);
    tick("stall0");
    tick("stall1");
    tick("stall2");
    chk("stall.ireq", {31'd0, bus.IReq}, 32'd0);
    chk("stall.pc",   bus.PC, 32'h0);
    chk("stall.cnt",  {16'd0, bus.FetchCnt}, 32'd11);
    set_in(0, 32'h0, 0, 26'h0, 0, 1);
    tick("unstall");
    chk("unstall.ireq", {31'd0, bus.IReq}, 32'd1);
    tick("resume");
    chk("resume.pc", bus.PC, 32'h4);

    // Async reset pulsed mid-REQ between edges.
    #2;
    Rst_n = 1'b0;
    #1;
    chk("areset.pc",   bus.PC, 32'h0);
    chk("areset.ireq", {31'd0, bus.IReq}, 32'd0);
    chk("areset.cnt",  {16'd0, bus.FetchCnt}, 32'd0);
    @(posedge Clk);
    #1;
    chk("areset.hold_cnt", {16'd0, bus.FetchCnt}, 32'd0);
    Rst_n = 1'b1;
    model_reset();
    tick("post_idle");
    tick("post_seq0");
    chk("post.pc", bus.PC, 32'h4);
    chk("sb.empty", sb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
